// File: rtl/dmarb_pkg.sv
// Shared definitions for the two-requester data memory arbiter.
package dmarb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  src;
  } dmarb_cmd_t;
endpackage

// File: rtl/dmarb_rr_picker.sv
// Two-way grant logic with a last-granted pointer, round-robin or fixed priority.
module dmarb_rr_picker
  import dmarb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o
);
  logic last_q, last_d;

  // On a tie requester 0 wins when requester 1 was granted last (or always, without RR).
  always_comb begin
    grant0_o = valid0_i & (~valid1_i | (RR_EN ? (last_q == REQ_DMA) : 1'b1));
    grant1_o = valid1_i & ~grant0_o;
    last_d   = last_q;
    if (grant0_o)      last_d = REQ_CPU;
    else if (grant1_o) last_d = REQ_DMA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= REQ_DMA;
    else         last_q <= last_d;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto the single-port data memory and routes read data back.
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              dmarb_clk,
  input  logic              dmarb_rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_wr_rd,
  input  logic [DATA_W-1:0] mem_data_out
);
  logic       gnt0, gnt1, fire;
  dmarb_cmd_t cmd;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              src_q, src_d;
  logic              rv0_q, rv0_d, rv1_q, rv1_d;

  dmarb_rr_picker #(.RR_EN(RR_EN)) u_picker (
    .clk_i    (dmarb_clk),
    .rst_ni   (dmarb_rst_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant0_o (gnt0),
    .grant1_o (gnt1)
  );

  always_comb begin
    fire = gnt0 | gnt1;
    if (gnt1) cmd = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, src: REQ_DMA};
    else      cmd = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, src: REQ_CPU};

    // S1: without a fire the port carries a read bubble with address/data held.
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    src_d   = src_q;
    if (fire) begin
      addr_d  = cmd.addr;
      wdata_d = cmd.wdata;
      wr_d    = cmd.we;
      rd_d    = ~cmd.we;
      src_d   = cmd.src;
    end

    // S2: read response tag lines up with the memory's registered read data.
    rv0_d = rd_q & (src_q == REQ_CPU);
    rv1_d = rd_q & (src_q == REQ_DMA);
  end

  always_ff @(posedge dmarb_clk or negedge dmarb_rst_n) begin
    if (!dmarb_rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      src_q   <= REQ_CPU;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      src_q   <= src_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_wr_rd   = wr_q;
  assign req0_rvalid = rv0_q;
  assign req1_rvalid = rv1_q;
  assign req0_rdata  = mem_data_out;
  assign req1_rdata  = mem_data_out;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256x8 registered-read memory.
module tb_data_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_wr_rd;

  logic       fp_ready0, fp_rvalid0, fp_ready1, fp_rvalid1, fp_wr_rd;
  logic [7:0] fp_rdata0, fp_rdata1, fp_address, fp_data_in;

  logic [7:0] mem [256];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  end

  always @(posedge clk) begin
    if (mem_wr_rd) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b1)) dut (
    .dmarb_clk(clk), .dmarb_rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wr_rd(mem_wr_rd),
    .mem_data_out(mem_data_out)
  );

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b0)) dut_fp (
    .dmarb_clk(clk), .dmarb_rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(fp_ready0), .req0_rvalid(fp_rvalid0), .req0_rdata(fp_rdata0),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(fp_ready1), .req1_rvalid(fp_rvalid1), .req1_rdata(fp_rdata1),
    .mem_address(fp_address), .mem_data_in(fp_data_in), .mem_wr_rd(fp_wr_rd),
    .mem_data_out(mem_data_out)
  );

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_address, mem_data_in, mem_wr_rd, req0_rvalid, req1_rvalid, req0_ready, req1_ready} !== 21'h0) begin
      bad++;
      $display("FAIL reset_rr: got addr=%h din=%h wr=%b rv=%b%b rdy=%b%b want all 0",
               mem_address, mem_data_in, mem_wr_rd, req0_rvalid, req1_rvalid, req0_ready, req1_ready);
    end
    total++;
    if ({fp_address, fp_data_in, fp_wr_rd, fp_rvalid0, fp_rvalid1, fp_ready0, fp_ready1} !== 21'h0) begin
      bad++;
      $display("FAIL reset_fp: got addr=%h din=%h wr=%b rv=%b%b rdy=%b%b want all 0",
               fp_address, fp_data_in, fp_wr_rd, fp_rvalid0, fp_rvalid1, fp_ready0, fp_ready1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1 req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL read_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_wr_rd !== 1'b0 || mem_address !== 8'h10 || req0_rvalid !== 1'b0) begin
      bad++; $display("FAIL read_s1: got wr=%b addr=%h rv=%b want 0 10 0", mem_wr_rd, mem_address, req0_rvalid);
    end
    @(negedge clk);
    total++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 8'h10 || req1_rvalid !== 1'b0) begin
      bad++; $display("FAIL read_s2: got rv0=%b rdata=%h rv1=%b want 1 10 0", req0_rvalid, req0_rdata, req1_rvalid);
    end
    @(negedge clk);
    total++;
    if (req0_rvalid !== 1'b0) begin
      bad++; $display("FAIL read_pulse: got rv0=%b want 0", req0_rvalid);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1 req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'hA5;
    @(posedge clk); #1 req1_we = 1'b0;
    @(negedge clk);
    total++;
    if (mem_wr_rd !== 1'b1 || mem_address !== 8'h20 || mem_data_in !== 8'hA5 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL wr_s1: got wr=%b addr=%h din=%h rdy1=%b want 1 20 a5 1",
                      mem_wr_rd, mem_address, mem_data_in, req1_ready);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_wr_rd !== 1'b0 || req1_rvalid !== 1'b0) begin
      bad++; $display("FAIL wr_no_resp: got wr=%b rv1=%b want 0 0", mem_wr_rd, req1_rvalid);
    end
    @(negedge clk);
    total++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 8'hA5 || req0_rvalid !== 1'b0) begin
      bad++; $display("FAIL raw_hazard: got rv1=%b rdata=%h rv0=%b want 1 a5 0", req1_rvalid, req1_rdata, req0_rvalid);
    end
  endtask

  task automatic test_rr_contention();
    apply_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h40;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h50;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        total++;
        if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
          bad++; $display("FAIL rr_grant%0d: got rdy=%b%b want %b%b", i, req0_ready, req1_ready,
                          (i % 2 == 0), (i % 2 == 1));
        end
      end
      if (i >= 2) begin
        total++;
        if (req0_rvalid !== (i % 2 == 0) || req1_rvalid !== (i % 2 == 1) ||
            mem_data_out !== ((i % 2 == 0) ? 8'h40 : 8'h50)) begin
          bad++; $display("FAIL rr_resp%0d: got rv=%b%b data=%h want %b%b %h", i, req0_rvalid, req1_rvalid,
                          mem_data_out, (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 8'h40 : 8'h50);
        end
      end
      @(posedge clk);
      if (i == 3) begin #1 req0_valid = 1'b0; req1_valid = 1'b0; end
    end
  endtask

  task automatic test_fixed_priority();
    @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
    req0_we = 1'b0; req1_we = 1'b0; req0_addr = 8'h11; req1_addr = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (fp_ready0 !== 1'b1 || fp_ready1 !== 1'b0) begin
        bad++; $display("FAIL fp_hold%0d: got rdy=%b%b want 10", i, fp_ready0, fp_ready1);
      end
      if (i >= 2) begin
        total++;
        if (fp_rvalid0 !== 1'b1 || fp_rvalid1 !== 1'b0) begin
          bad++; $display("FAIL fp_resp%0d: got rv=%b%b want 10", i, fp_rvalid0, fp_rvalid1);
        end
      end
      @(posedge clk);
    end
    #1 req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (fp_ready0 !== 1'b0 || fp_ready1 !== 1'b1) begin
      bad++; $display("FAIL fp_release: got rdy=%b%b want 01", fp_ready0, fp_ready1);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    @(posedge clk); #1 req0_valid = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if (mem_wr_rd !== 1'b0 || mem_address !== 8'h00) begin
      bad++; $display("FAIL rstmid_rd_s1: got wr=%b addr=%h want 0 00", mem_wr_rd, mem_address);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
        bad++; $display("FAIL rstmid_rvalid%0d: got rv=%b%b want 00", i, req0_rvalid, req1_rvalid);
      end
      if (i == 0) begin @(posedge clk); #1 rst_n = 1'b1; end
    end
    @(posedge clk); #1 req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h61; req1_wdata = 8'hEE;
    @(posedge clk); #1 req1_valid = 1'b0; req1_we = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if (mem_wr_rd !== 1'b0) begin
      bad++; $display("FAIL rstmid_wr_drop: got wr=%b want 0", mem_wr_rd);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 req0_valid = 1'b1; req0_we = 1'b0; req0_addr = (k == 0) ? 8'h33 : 8'h61;
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      total++;
      if (req0_rvalid !== 1'b1 || req0_rdata !== ((k == 0) ? 8'h33 : 8'h61)) begin
        bad++; $display("FAIL rstmid_after%0d: got rv=%b rdata=%h want 1 %h", k, req0_rvalid, req0_rdata,
                        (k == 0) ? 8'h33 : 8'h61);
      end
    end
  endtask

  task automatic test_idle();
    int errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (mem_wr_rd !== 1'b0 || req0_rvalid !== 1'b0 || req1_rvalid !== 1'b0) begin
        bad++; $display("FAIL idle%0d: got wr=%b rv=%b%b want 0 00", i, mem_wr_rd, req0_rvalid, req1_rvalid);
      end
    end
    for (int a = 0; a < 256; a++) begin
      logic [7:0] want;
      want = (a == 'h20) ? 8'hA5 : a[7:0];
      if (mem[a] !== want) begin
        errs++;
        if (errs == 1) $display("FAIL mem_contents: got mem[%h]=%h want %h", a[7:0], mem[a], want);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_rr_contention();
    test_fixed_priority();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 single-port data memory.
- Memory interface:
  - One shared address/data/wr_rd port.
  - Writes occur on a clock edge.
  - Read data is registered one edge after the address is applied.
- Accepts at most one command per cycle (round-robin or fixed priority), registers it onto the memory port, and routes read data back to the issuing requester.
- Sits between the CPU load/store unit (requester 0) and the DMA/peripheral engine (requester 1).

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- dmarb_clk  in  1  single clock, shared with the data memory.
- dmarb_rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_we  in  1  requester 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  requester 0 address.
- req0_wdata  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_rvalid  out  1  requester 0 read data valid.
- req0_rdata  out  DATA_W  requester 0 read data.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same definitions as requester 0, for requester 1.
- mem_address  out  ADDR_W  registered memory address.
- mem_data_in  out  DATA_W  registered memory write data.
- mem_wr_rd  out  1  registered memory command: 1 = write, 0 = read.
- mem_data_out  in  DATA_W  memory registered read data.

Behaviour:
- Clock/reset: one clock (dmarb_clk). dmarb_rst_n is asynchronous, active-low.
- Reset values (all outputs 0):
  - mem_address = 0, mem_data_in = 0, mem_wr_rd = 0.
  - reqN_rvalid = 0.
  - Pipeline tags cleared.
  - RR pointer = 1, so requester 0 wins the first tie.
- Handshake:
  - Requester holds valid/we/addr/wdata stable until it sees ready.
  - A command fires on the edge where valid && ready.
  - ready is combinational from the valids and the RR pointer; at most one ready is high per cycle.
  - ready never asserts without the matching valid.
- Arbitration:
  - Only one valid high: that requester gets ready.
  - Both valid, RR_EN=1: grant the requester that was not granted last.
  - Both valid, RR_EN=0: requester 0 always wins.
  - RR pointer updates only on a fire.
- Pipeline, command fires at edge T:
  - Stage S1, cycle T+1: mem_address/mem_data_in/mem_wr_rd hold the command. The memory writes, or latches read data, at edge T+1.
  - Stage S2, cycle T+2: if the command was a read, reqN_rvalid=1 for exactly one cycle and reqN_rdata = mem_data_out.
  - Read latency is 2 cycles from the fire edge.
  - Writes produce no response.
- Throughput: one command per cycle sustained. Back-to-back commands from the same or different requesters are allowed.
- Ordering and hazards:
  - Strictly in order.
  - Write at T followed by a read of the same address at T+1 returns the new data.
  - No forwarding logic is needed.
- Idle:
  - With no fire, S1 carries a bubble: mem_wr_rd=0, address and data unchanged.
  - No write may ever reach the memory without a fired write command.
- Response outputs:
  - Only one requester's rvalid is high in any cycle.
  - reqN_rdata = mem_data_out at all times; it is qualified only by rvalid.
- Reset mid-operation:
  - Asserting reset immediately forces mem_wr_rd=0 and clears both stages.
  - In-flight reads produce no rvalid; an in-flight write whose edge has not yet occurred is dropped.
- Address and data are passed through at full width, with no arithmetic.

Decomposition:
- Shared package dmarb_pkg:
  - ADDR_W/DATA_W defaults.
  - Requester-ID constants REQ_CPU=0 and REQ_DMA=1.
  - Command type {we, addr, wdata, src}.
- One natural sub-module: dmarb_rr_picker, the combinational 2-way grant logic plus the pointer register.
- Pipeline stages stay in the top module.

Test Plan:
- Memory preloaded with data_mem[i]=i.
- Read: req0 read addr 0x10 fires at T -> mem_wr_rd=0, mem_address=0x10 in T+1; req0_rvalid=1, req0_rdata=0x10 at T+2; req1_rvalid stays 0.
- Write then read: req1 write 0xA5 to 0x20 at T, req1 read 0x20 at T+1 -> req1_rdata=0xA5 with rvalid at T+3.
- RR_EN=1 contention: both valid for 4 cycles after reset -> grants 0,1,0,1; each requester sees its own rvalid.
- RR_EN=0 contention: both valid continuously -> req1_ready never asserts until req0_valid drops, then asserts the next cycle.
- Reset mid-read: fire a read, assert rst_n=0 in T+1 -> no rvalid ever; mem_wr_rd=0 immediately; after release, a read of 0x33 returns 0x33.
- Idle: 20 cycles with no valid -> mem_wr_rd=0 throughout; memory contents unchanged.
